// File: rtl/pipeline_stall_ctrl.sv
// Front-end stall/flush sequencer for the 5-stage pipeline.
// Converts hazard, branch/jump and halt requests into PC/IF-ID/ID-EX
// enables. Tracks stall episodes in a small FSM, keeps saturating
// performance counters and raises a sticky watchdog if a stall never clears.
module pipeline_stall_ctrl #(
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             HazardStall,
  input  logic             BranchTaken,
  input  logic             JumpTaken,
  input  logic             Halt,
  input  logic             ClearCounters,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             StallTimeout,
  output logic [1:0]       State
);

  localparam int unsigned RUN_W = 8;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);
  localparam logic [RUN_W-1:0] RUN_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] runCnt;
  logic             frz;
  logic             stallInc;
  logic             stallRun;
  logic             flush;

  // Mealy control outputs: halt beats hazard, hazard beats branch/jump.
  always_comb begin
    frz      = Halt || (state == ST_HALT);
    stallInc = HazardStall && !frz;
    stallRun = (state == ST_STALL) && HazardStall && !Halt;
    flush    = !frz && !HazardStall && (BranchTaken || JumpTaken);
  end

  assign PCWrite      = !frz && !HazardStall;
  assign IF_ID_Write  = !frz && !HazardStall;
  assign IF_ID_Flush  = flush;
  assign ID_EX_Bubble = frz || HazardStall;
  assign State        = 2'(state);

  // Stall-episode FSM; a hazard pending after halt is re-evaluated from RUN.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (Halt)             state <= ST_HALT;
          else if (HazardStall) state <= ST_STALL;
        end
        ST_STALL: begin
          if (Halt)              state <= ST_HALT;
          else if (!HazardStall) state <= ST_RUN;
        end
        ST_HALT: begin
          if (!Halt) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Saturating counters and sticky watchdog; clear beats any increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCount   <= '0;
      FlushCount   <= '0;
      StallTimeout <= 1'b0;
      runCnt       <= '0;
    end else if (ClearCounters) begin
      StallCount   <= '0;
      FlushCount   <= '0;
      StallTimeout <= 1'b0;
      runCnt       <= '0;
    end else begin
      if (stallInc && (StallCount != CNT_ONES)) StallCount <= StallCount + CNT_W'(1);
      if (flush && (FlushCount != CNT_ONES))    FlushCount <= FlushCount + CNT_W'(1);
      if (stallRun) begin
        if (runCnt == RUN_LAST) StallTimeout <= 1'b1;
        if (runCnt != RUN_ONES) runCnt <= runCnt + RUN_W'(1);
      end else begin
        runCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: a reference model pushes the
// expected outputs each cycle; a monitor pops and compares them.
module tb_pipeline_stall_ctrl;

  localparam int unsigned MAX_STALL = 8;
  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             HazardStall = 1'b0;
  logic             BranchTaken = 1'b0;
  logic             JumpTaken = 1'b0;
  logic             Halt = 1'b0;
  logic             ClearCounters = 1'b0;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic             StallTimeout;
  logic [1:0]       State;

  pipeline_stall_ctrl #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .HazardStall(HazardStall), .BranchTaken(BranchTaken),
    .JumpTaken(JumpTaken), .Halt(Halt), .ClearCounters(ClearCounters),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .StallCount(StallCount), .FlushCount(FlushCount),
    .StallTimeout(StallTimeout), .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic             pcw, ifw, fl, bub, to;
    logic [1:0]       st;
    logic [CNT_W-1:0] sc, fc;
    int               tag;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  int curTag = 0;

  // Reference model state
  logic [1:0]       mState;
  logic [CNT_W-1:0] mSc, mFc;
  logic             mTo;
  int               mRun;

  task automatic resetModel();
    mState = 2'd0; mSc = '0; mFc = '0; mTo = 1'b0; mRun = 0;
  endtask

  // One clock of stimulus: drive at negedge, push expectation, advance model.
  task automatic cyc(input logic hs, input logic br, input logic jp, input logic hl, input logic cl);
    exp_t e;
    logic frz;
    @(negedge Clk);
    HazardStall = hs; BranchTaken = br; JumpTaken = jp; Halt = hl; ClearCounters = cl;
    frz   = hl || (mState == 2'd2);
    e.pcw = !frz && !hs;
    e.ifw = !frz && !hs;
    e.fl  = !frz && !hs && (br || jp);
    e.bub = frz || hs;
    e.st  = mState; e.sc = mSc; e.fc = mFc; e.to = mTo; e.tag = curTag;
    sbq.push_back(e);
    if (!Rst_n) begin
      resetModel();
    end else begin
      if (cl) begin
        mSc = '0; mFc = '0; mTo = 1'b0; mRun = 0;
      end else begin
        if (hs && !frz && (mSc != CNT_MAX)) mSc = mSc + CNT_W'(1);
        if (e.fl && (mFc != CNT_MAX))       mFc = mFc + CNT_W'(1);
        if ((mState == 2'd1) && hs && !hl) begin
          if (mRun == int'(MAX_STALL) - 1) mTo = 1'b1;
          mRun = mRun + 1;
        end else begin
          mRun = 0;
        end
      end
      case (mState)
        2'd0:    mState = hl ? 2'd2 : (hs ? 2'd1 : 2'd0);
        2'd1:    mState = hl ? 2'd2 : (hs ? 2'd1 : 2'd0);
        default: mState = hl ? 2'd2 : 2'd0;
      endcase
    end
  endtask

  // Monitor: pop one expectation per cycle and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, StallTimeout, State, StallCount, FlushCount} !==
            {e.pcw, e.ifw, e.fl, e.bub, e.to, e.st, e.sc, e.fc}) begin
          miscompares++;
          $display("FAIL sb test%0d t=%0t got pcw=%b ifw=%b fl=%b bub=%b to=%b st=%0d sc=%0d fc=%0d exp pcw=%b ifw=%b fl=%b bub=%b to=%b st=%0d sc=%0d fc=%0d",
                   e.tag, $time, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, StallTimeout, State, StallCount, FlushCount,
                   e.pcw, e.ifw, e.fl, e.bub, e.to, e.st, e.sc, e.fc);
        end
      end
    end
  end

  task automatic test_reset();
    curTag = 1;
    Rst_n = 1'b0;
    resetModel();
    #2;
    vectors++; if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} !== 4'b1100) begin
      miscompares++; $display("FAIL reset_ctrl got=%b exp=1100", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}); end
    vectors++; if ({State, StallCount, FlushCount, StallTimeout} !== '0) begin
      miscompares++; $display("FAIL reset_regs got st=%0d sc=%0d fc=%0d to=%b exp all 0", State, StallCount, FlushCount, StallTimeout); end
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    curTag = 2;
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if (StallCount !== CNT_W'(3)) begin miscompares++; $display("FAIL stall_count got=%0d exp=3", StallCount); end
    vectors++; if (State !== 2'd1) begin miscompares++; $display("FAIL stall_state got=%0d exp=1", State); end
    vectors++; if (StallTimeout !== 1'b0) begin miscompares++; $display("FAIL stall_timeout got=%b exp=0", StallTimeout); end
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL stall_back_run got=%0d exp=0", State); end
  endtask

  task automatic test_branch();
    curTag = 3;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    #3;
    vectors++; if ({IF_ID_Flush, PCWrite} !== 2'b00) begin miscompares++; $display("FAIL br_stalled got fl,pcw=%b exp=00", {IF_ID_Flush, PCWrite}); end
    cyc(0, 1, 0, 0, 0);
    #3;
    vectors++; if ({IF_ID_Flush, PCWrite} !== 2'b11) begin miscompares++; $display("FAIL br_flush got fl,pcw=%b exp=11", {IF_ID_Flush, PCWrite}); end
    cyc(0, 1, 1, 0, 0);
    #3;
    vectors++; if (FlushCount !== CNT_W'(1)) begin miscompares++; $display("FAIL br_count got=%0d exp=1", FlushCount); end
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if (FlushCount !== CNT_W'(3)) begin miscompares++; $display("FAIL br_jump_count got=%0d exp=3", FlushCount); end
  endtask

  task automatic test_watchdog();
    curTag = 4;
    cyc(0, 0, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, 0, 0);
    #3;
    vectors++; if (StallTimeout !== 1'b0) begin miscompares++; $display("FAIL wd_early got=%b exp=0", StallTimeout); end
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if (StallTimeout !== 1'b1) begin miscompares++; $display("FAIL wd_set got=%b exp=1", StallTimeout); end
    vectors++; if (StallCount !== CNT_W'(10)) begin miscompares++; $display("FAIL wd_count got=%0d exp=10", StallCount); end
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if (StallTimeout !== 1'b1) begin miscompares++; $display("FAIL wd_sticky got=%b exp=1", StallTimeout); end
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if ({StallTimeout, StallCount} !== '0) begin miscompares++; $display("FAIL wd_clear got to=%b sc=%0d exp 0", StallTimeout, StallCount); end
  endtask

  task automatic test_halt();
    curTag = 5;
    cyc(0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 1, 0);
      #3;
      vectors++; if ({PCWrite, ID_EX_Bubble, IF_ID_Flush} !== 3'b010) begin
        miscompares++; $display("FAIL halt_freeze%0d got pcw,bub,fl=%b exp=010", i, {PCWrite, ID_EX_Bubble, IF_ID_Flush}); end
    end
    #1;
    vectors++; if ({State, StallCount} !== {2'd2, CNT_W'(2)}) begin
      miscompares++; $display("FAIL halt_hold got st=%0d sc=%0d exp st=2 sc=2", State, StallCount); end
    cyc(1, 0, 0, 0, 0);
    #3;
    vectors++; if ({State, PCWrite} !== {2'd2, 1'b0}) begin miscompares++; $display("FAIL halt_drop got st=%0d pcw=%b exp 2,0", State, PCWrite); end
    cyc(1, 0, 0, 0, 0);
    #3;
    vectors++; if (State !== 2'd0) begin miscompares++; $display("FAIL halt_run got=%0d exp=0", State); end
    cyc(1, 0, 0, 0, 0);
    #3;
    vectors++; if (State !== 2'd1) begin miscompares++; $display("FAIL halt_restall got=%0d exp=1", State); end
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if (StallCount !== CNT_W'(4)) begin miscompares++; $display("FAIL halt_count got=%0d exp=4", StallCount); end
  endtask

  task automatic test_saturation();
    curTag = 6;
    cyc(0, 0, 0, 0, 1);
    repeat (260) cyc(1, 0, 0, 0, 0);
    repeat (260) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if (StallCount !== CNT_MAX) begin miscompares++; $display("FAIL sat_stall got=%0d exp=%0d", StallCount, CNT_MAX); end
    vectors++; if (FlushCount !== CNT_MAX) begin miscompares++; $display("FAIL sat_flush got=%0d exp=%0d", FlushCount, CNT_MAX); end
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    #3;
    vectors++; if ({StallCount, FlushCount} !== '0) begin miscompares++; $display("FAIL sat_clear got sc=%0d fc=%0d exp 0", StallCount, FlushCount); end
  endtask

  task automatic test_reset_mid_stall();
    curTag = 7;
    cyc(0, 0, 0, 0, 1);
    repeat (2) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    #3;
    Rst_n = 1'b0; HazardStall = 1'b0;
    #1;
    resetModel();
    vectors++; if ({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble} !== 4'b1100) begin
      miscompares++; $display("FAIL rst_mid_ctrl got=%b exp=1100", {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}); end
    vectors++; if ({State, StallCount, FlushCount, StallTimeout} !== '0) begin
      miscompares++; $display("FAIL rst_mid_regs got st=%0d sc=%0d fc=%0d to=%b exp 0", State, StallCount, FlushCount, StallTimeout); end
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_watchdog();
    test_halt();
    test_saturation();
    test_reset_mid_stall();
    @(negedge Clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Sequencing controller for the 5-stage pipeline's front end. It turns the hazard detector's combinational stall request, the decode-stage branch/jump resolution and an external halt request into the per-cycle enables and flushes for the PC, IF/ID and ID/EX registers. It tracks stall episodes in a small FSM, keeps saturating performance counters, and raises a sticky watchdog flag if a stall never clears. It sits between the hazard detector, the decode-stage branch comparator and the pipeline register enables in the top-level datapath.

## Interface
- MAX_STALL, 8: consecutive stall cycles that trip the watchdog (1..255).
- CNT_W, 32: width of the performance counters.
- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- HazardStall  in  1  stall request from the hazard detector (1 = ID instruction must wait).
- BranchTaken  in  1  branch resolved taken in ID this cycle.
- JumpTaken  in  1  jump in ID this cycle.
- Halt  in  1  freeze request (debug/end of program), level-sensitive.
- ClearCounters  in  1  synchronous clear of StallCount, FlushCount and StallTimeout.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  IF/ID loads a nop (wrong-path fetch squash).
- ID_EX_Bubble  out  1  ID/EX control fields forced to nop.
- StallCount  out  CNT_W  total stall cycles, saturating.
- FlushCount  out  CNT_W  total flush events, saturating.
- StallTimeout  out  1  sticky watchdog flag.
- State  out  2  FSM state, for debug: 0 RUN, 1 STALL, 2 HALT.

## Operation
- FSM: RUN, STALL, HALT. The state register is clocked; the outputs are Mealy (current state plus current inputs).
- Transitions:
  - RUN → HALT if Halt; else → STALL if HazardStall; else stay in RUN.
  - STALL → HALT if Halt; else → RUN if !HazardStall; else stay in STALL.
  - HALT → RUN when !Halt. Any pending HazardStall is re-evaluated from RUN on the next cycle.
- Define frz = Halt || (State == HALT).
- Output equations:
  - PCWrite = IF_ID_Write = !frz && !HazardStall.
  - ID_EX_Bubble = frz || HazardStall.
  - IF_ID_Flush = !frz && !HazardStall && (BranchTaken || JumpTaken).
- Priority is Halt > HazardStall > branch/jump. BranchTaken and JumpTaken are ignored while stalled, because the operands are not yet valid. When a flush is issued, PCWrite = 1 so the target is loaded.
- Run counter (8 bits, internal):
  - Increments each cycle the FSM is in STALL with HazardStall=1 and !Halt.
  - Cleared on any cycle without that condition.
  - When it reaches MAX_STALL-1 while the increment condition holds, StallTimeout is set on the next edge. It stays set until reset or ClearCounters.
- StallCount increments on every cycle with HazardStall && !frz, regardless of state.
- FlushCount increments on every cycle IF_ID_Flush = 1.
- Both counters saturate at all-ones and never wrap.
- ClearCounters zeroes StallCount, FlushCount, StallTimeout and the run counter. If ClearCounters coincides with an increment, the clear wins and the result is 0.

## Timing
- Reset (asynchronous, Rst_n=0):
  - State = RUN; all counters 0; StallTimeout = 0.
  - Outputs follow the equations immediately, so with all inputs 0: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
- Release is synchronous to the first rising edge with Rst_n=1.
- Control outputs have zero-cycle latency from their inputs (combinational path). Counters, State and StallTimeout update one edge after the qualifying cycle.
- A stall of N cycles produces exactly N cycles of PCWrite=0 and N bubbles, and increments StallCount by N.
- Halt asserted mid-stall: the outputs freeze immediately; StallCount does not advance while frozen.
- Reset asserted mid-stall or mid-halt: the block returns to the reset values immediately, with no pending flush or stall carried over.
- A simultaneous BranchTaken and JumpTaken counts as one flush.

## Test plan
- Reset with all inputs 0 → PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, State=0, StallCount=0, FlushCount=0.
- HazardStall=1 for 3 cycles then 0 → 3 cycles of PCWrite=0/ID_EX_Bubble=1, State goes RUN→STALL→RUN, StallCount=3, StallTimeout=0.
- BranchTaken=1 together with HazardStall=1, then BranchTaken=1 alone → no flush in the first cycle; IF_ID_Flush=1 with PCWrite=1 in the second; FlushCount=1.
- With MAX_STALL=8, hold HazardStall=1 for 10 cycles → StallTimeout=1 after the 8th stall cycle and stays 1 after the stall clears; ClearCounters=1 for one cycle → StallTimeout=0, StallCount=0.
- Halt=1 during a 2-cycle-old stall for 4 cycles, with HazardStall held → PCWrite=0, ID_EX_Bubble=1 throughout, State=2, StallCount stays 2; after Halt drops, State goes HALT→RUN→STALL.
- Preload counters near all-ones (force StallCount to 2^CNT_W-2), then stall 3 cycles → StallCount saturates at all-ones. Rst_n pulsed low mid-stall → all outputs return to reset values within the same cycle.
